// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the shared-memory arbiter: state encoding,
// default bus widths and the width of a core index.
package gpu_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int CORE_ID_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns the first requester found
// searching upward from last_grant+1 with wrap-around.
module rr_picker
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES = 4
) (
  input  logic [N_CORES-1:0]   req,
  input  logic [CORE_ID_W-1:0] last_grant,
  output logic [CORE_ID_W-1:0] grant,
  output logic                 any_req
);

  int                 idx;
  logic [N_CORES-1:0] shifted;

  // Walk candidates from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    shifted = '0;
    for (int i = N_CORES; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= N_CORES) idx = idx - N_CORES;
      shifted = req >> idx;
      if (shifted[0]) grant = CORE_ID_W'(idx);
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising load/store requests from N cores onto a
// single-port shared memory. Optional memory timeout: define ARB_TIMEOUT_EN.
module shared_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        mem_req_ld,
  input  logic [N_CORES-1:0]        mem_req_st,
  input  logic [N_CORES*ADDR_W-1:0] addr_flat,
  input  logic [N_CORES*DATA_W-1:0] wdata_flat,
  output logic [N_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]         mem_dat,
  output logic [CORE_ID_W-1:0]      grant_id,
  output logic                      busy,
  output logic                      sm_req,
  output logic                      sm_we,
  output logic [ADDR_W-1:0]         sm_addr,
  output logic [DATA_W-1:0]         sm_wdata,
  input  logic                      sm_ack,
  input  logic [DATA_W-1:0]         sm_rdata,
  output logic                      err
);

  if (N_CORES < 2 || N_CORES > 16 || TIMEOUT < 1) begin : g_cfg_check
    $error("shared_mem_arbiter: unsupported parameter set");
  end

  arb_state_e           state, state_nxt;
  logic [N_CORES-1:0]   req;
  logic [CORE_ID_W-1:0] last_grant;
  logic [CORE_ID_W-1:0] pick;
  logic                 any_req;
  logic                 in_xfer;
  logic                 take;
  logic                 timeout_hit;
  logic                 ld_sel;
  logic [ADDR_W-1:0]    addr_sel;
  logic [DATA_W-1:0]    wdata_sel;

  // A core holding both request lines is serviced as a load.
  assign req       = mem_req_ld | mem_req_st;
  assign in_xfer   = (state == ISSUE) || (state == WAIT);
  assign take      = (state == IDLE) && any_req;
  assign ld_sel    = |(mem_req_ld & (N_CORES'(1) << pick));
  assign addr_sel  = ADDR_W'(addr_flat >> (int'(pick) * ADDR_W));
  assign wdata_sel = DATA_W'(wdata_flat >> (int'(pick) * DATA_W));

  rr_picker #(
    .N_CORES (N_CORES)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode; val_data and sm_req follow the state directly
  // so an asynchronous reset clears them without waiting for a clock edge.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    sm_req    = in_xfer;
    val_data  = '0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE, WAIT: begin
        if (sm_ack || timeout_hit) state_nxt = RESP;
        else                       state_nxt = WAIT;
      end
      RESP: begin
        val_data  = N_CORES'(1) << grant_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request at grant time and capture load data on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= CORE_ID_W'(N_CORES - 1);
      grant_id   <= '0;
      sm_we      <= 1'b0;
      sm_addr    <= '0;
      sm_wdata   <= '0;
      mem_dat    <= '0;
    end else begin
      if (take) begin
        last_grant <= pick;
        grant_id   <= pick;
        sm_we      <= ~ld_sel;
        sm_addr    <= addr_sel;
        sm_wdata   <= wdata_sel;
      end
      if (in_xfer && sm_ack) begin
        if (!sm_we) mem_dat <= sm_rdata;
      end else if (timeout_hit) begin
        mem_dat <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The last waiting cycle is the TIMEOUT-th one spent in ISSUE/WAIT.
  assign timeout_hit = in_xfer && !sm_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Count cycles waiting on memory; err stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (in_xfer && !sm_ack && !timeout_hit) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                                    tmo_cnt <= '0;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: a memory responder model,
// a scoreboard of expected completions and a bus monitor.
module tb_shared_mem_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 8;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    mem_req_ld;
  logic [NC-1:0]    mem_req_st;
  logic [NC*AW-1:0] addr_flat;
  logic [NC*DW-1:0] wdata_flat;
  logic [NC-1:0]    val_data;
  logic [DW-1:0]    mem_dat;
  logic [3:0]       grant_id;
  logic             busy;
  logic             sm_req;
  logic             sm_we;
  logic [AW-1:0]    sm_addr;
  logic [DW-1:0]    sm_wdata;
  logic             sm_ack;
  logic [DW-1:0]    sm_rdata;
  logic             err;

  shared_mem_arbiter #(
    .N_CORES (NC),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req_ld (mem_req_ld),
    .mem_req_st (mem_req_st),
    .addr_flat  (addr_flat),
    .wdata_flat (wdata_flat),
    .val_data   (val_data),
    .mem_dat    (mem_dat),
    .grant_id   (grant_id),
    .busy       (busy),
    .sm_req     (sm_req),
    .sm_we      (sm_we),
    .sm_addr    (sm_addr),
    .sm_wdata   (sm_wdata),
    .sm_ack     (sm_ack),
    .sm_rdata   (sm_rdata),
    .err        (err)
  );

  typedef struct {
    int         core;
    bit         is_load;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] bmem    [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            ack_enable;
  int            ack_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a) ^ DW'(a >> 4) ^ 8'hA5;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks an outstanding request after ack_delay extra cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    sm_ack   = 1'b0;
    sm_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      sm_ack = 1'b0;
      if (sm_req && ack_enable) begin
        if (wait_cnt >= ack_delay) begin
          sm_ack   = 1'b1;
          sm_rdata = sm_we ? 8'hEE : bmem[sm_addr];
          if (sm_we) bmem[sm_addr] = sm_wdata;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard pop on each completion pulse, plus memory-bus monitor.
  initial begin
    exp_t          cur;
    logic          prev_req;
    logic          prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [DW-1:0] last_dat;
    prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0; last_dat = '0;
    forever begin
      @(negedge clk);
      if (reset && val_data != '0) begin
        check("sb_pop", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("val_data", 32'(val_data), 32'(1) << cur.core);
          check("grant_id", 32'(grant_id), cur.core);
          if (cur.is_load) check("mem_dat_ld", 32'(mem_dat), 32'(cur.rdata));
          else             check("mem_dat_st", 32'(mem_dat), 32'(last_dat));
        end
      end
      if (sm_req && !prev_req && sb.size() > 0) begin
        check("sm_addr", 32'(sm_addr), 32'(sb[0].addr));
        check("sm_we", 32'(sm_we), 32'(!sb[0].is_load));
        if (!sb[0].is_load) check("sm_wdata", 32'(sm_wdata), 32'(sb[0].wdata));
      end
      if (sm_req && prev_req) begin
        check("sm_addr_stable", 32'(sm_addr), 32'(prev_addr));
        check("sm_we_stable", 32'(sm_we), 32'(prev_we));
        check("sm_wdata_stable", 32'(sm_wdata), 32'(prev_wdata));
      end
      prev_req   = sm_req;
      prev_we    = sm_we;
      prev_addr  = sm_addr;
      prev_wdata = sm_wdata;
      last_dat   = mem_dat;
    end
  end

  task automatic issue(input int core, input bit ld, input bit st,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit tmo);
    exp_t e;
    addr_flat[core*AW +: AW]  = a;
    wdata_flat[core*DW +: DW] = d;
    e.core    = core;
    e.is_load = ld;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = '0;
    if (tmo)     e.rdata = '0;
    else if (ld) e.rdata = ref_mem[a];
    else         ref_mem[a] = d;
    sb.push_back(e);
    mem_req_ld[core] = ld;
    mem_req_st[core] = st;
  endtask

  task automatic single(input int core, input bit ld, input bit st,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
    int cyc;
    issue(core, ld, st, a, d, 1'b0);
    cyc = 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      cyc++;
      if (val_data != '0) break;
    end
    check("latency", cyc, exp_lat);
    mem_req_ld[core] = 1'b0;
    mem_req_st[core] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input bit reissue0);
    bit did;
    did = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (val_data[k]) begin
          mem_req_ld[k] = 1'b0;
          mem_req_st[k] = 1'b0;
          if (reissue0 && k == 0 && !did) begin
            did = 1'b1;
            issue(0, 1'b1, 1'b0, 12'h0C4, 8'h00, 1'b0);
          end
        end
      end
      if (sb.size() == 0 && mem_req_ld == '0 && mem_req_st == '0) break;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    mem_req_ld = '0;
    mem_req_st = '0;
    addr_flat  = '0;
    wdata_flat = '0;
    ack_enable = 1'b1;
    ack_delay  = 0;
    for (int a = 0; a < 4096; a++) begin
      bmem[a]    = pat(a);
      ref_mem[a] = pat(a);
    end
    bmem[12'h3A5]    = 8'h5C;
    ref_mem[12'h3A5] = 8'h5C;

    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_sm_req", 32'(sm_req), 0);
    check("rst_val_data", 32'(val_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_dat", 32'(mem_dat), 0);
    check("rst_sm_addr", 32'(sm_addr), 0);
    check("rst_sm_we", 32'(sm_we), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single load, ack in ISSUE.
    single(2, 1'b1, 1'b0, 12'h3A5, 8'h00, 3);
    check("grant_hold", 32'(grant_id), 2);

    // Store with a 4-cycle ack delay, then read it back.
    ack_delay = 4;
    single(1, 1'b0, 1'b1, 12'h010, 8'hA7, 7);
    ack_delay = 0;
    single(1, 1'b1, 1'b0, 12'h010, 8'h00, 3);

    // Load and store together is a load.
    single(0, 1'b1, 1'b1, 12'h200, 8'h33, 3);

    // Round robin from a fresh reset with all cores requesting.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NC; k++) issue(k, 1'b1, 1'b0, AW'(12'h100 + k), 8'h00, 1'b0);
    drain(200, 1'b1);

    // Reset while waiting for the memory.
    ack_enable = 1'b0;
    issue(1, 1'b1, 1'b0, 12'h123, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("wait_busy", 32'(busy), 1);
    check("wait_sm_req", 32'(sm_req), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_sm_req", 32'(sm_req), 0);
    check("abort_val_data", 32'(val_data), 0);
    check("abort_busy", 32'(busy), 0);
    sb.delete();
    mem_req_ld = '0;
    mem_req_st = '0;
    @(posedge clk);
    #3;
    reset      = 1'b1;
    ack_enable = 1'b1;
    @(negedge clk);
    issue(0, 1'b1, 1'b0, 12'h321, 8'h00, 1'b0);
    issue(2, 1'b0, 1'b1, 12'h322, 8'h4D, 1'b0);
    drain(100, 1'b0);

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      ack_enable = 1'b0;
      issue(2, 1'b1, 1'b0, 12'h055, 8'h00, 1'b1);
      for (int c = 0; c < 20 && !sm_req; c++) @(negedge clk);
      for (int c = 0; c < 40 && sm_req; c++) begin
        n++;
        @(negedge clk);
      end
      check("tmo_req_cycles", n, TMO);
      mem_req_ld[2] = 1'b0;
      @(negedge clk);
      check("tmo_err", 32'(err), 1);
      ack_enable = 1'b1;
      single(3, 1'b1, 1'b0, 12'h0AA, 8'h00, 3);
      check("tmo_err_sticky", 32'(err), 1);
    end
`else
    check("err_tied", 32'(err), 0);
`endif

    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter that shares the single-port shared memory (12-bit address, 8-bit data) among N GPU cores.
- Each core presents a level load/store request with its address and store data, then waits for a one-cycle val_data pulse.
- Sits between the core array and the shared memory macro.
- Serialises exactly one transaction at a time and returns load data over a broadcast bus.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- ADDR_W, 12, shared memory address width.
- DATA_W, 8, data width.
- TIMEOUT, 255, max cycles to wait for sm_ack (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- mem_req_ld  in  N_CORES  per-core load request, level, held until that core's val_data.
- mem_req_st  in  N_CORES  per-core store request, level, held until that core's val_data.
- addr_flat  in  N_CORES*ADDR_W  core k address at [k*ADDR_W +: ADDR_W].
- wdata_flat  in  N_CORES*DATA_W  core k store data at [k*DATA_W +: DATA_W].
- val_data  out  N_CORES  one-hot, one-cycle completion pulse to the granted core.
- mem_dat  out  DATA_W  registered load data, valid in the val_data cycle, shared by all cores.
- grant_id  out  4  index of the core currently granted; held after completion.
- busy  out  1  high in every state except IDLE.
- sm_req  out  1  memory request, held until sm_ack.
- sm_we  out  1  1 = store, 0 = load; stable while sm_req is high.
- sm_addr  out  ADDR_W  memory address; stable while sm_req is high.
- sm_wdata  out  DATA_W  memory store data; stable while sm_req is high.
- sm_ack  in  1  memory completion, one cycle; sm_rdata is valid with it.
- sm_rdata  in  DATA_W  memory read data.
- err  out  1  sticky timeout flag; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset values (asynchronous, while reset=0): state=IDLE, all outputs 0, last_grant=N_CORES-1 (so core 0 wins first), timeout counter 0.
- Reset asserted mid-transaction aborts immediately. No val_data is issued for the aborted transaction. The requesting core is expected to be reset too.
- A core's request is req[k] = mem_req_ld[k] | mem_req_st[k]. If both are high, the transaction is a load.
- IDLE:
  - If any req is high, pick the first requester searching upward from (last_grant+1) mod N_CORES with wrap-around.
  - Latch its id, address, store data and type into sm_* registers.
  - Set last_grant and grant_id, go to ISSUE.
  - Requests arriving in the same cycle are resolved by the round-robin order only.
- ISSUE: sm_req=1 from this cycle on.
  - If sm_ack is high in this cycle, capture sm_rdata and go to RESP.
  - Otherwise go to WAIT.
- WAIT: hold sm_req and the sm_* fields stable. On sm_ack, capture sm_rdata into mem_dat (loads only; stores leave mem_dat unchanged), drop sm_req, go to RESP.
- RESP:
  - val_data[grant_id]=1 for exactly this cycle; sm_req=0.
  - Next state is IDLE.
  - The core clears its request on this edge, so IDLE never sees the stale request.
- Minimum latency from request high in IDLE to val_data: 3 cycles (ack in ISSUE). Each extra ack wait cycle adds 1.
- Fairness: with all N cores requesting continuously, grants are issued strictly 0,1,...,N-1,0,...
- sm_ack outside ISSUE/WAIT is ignored.
- A core's request dropping before completion is not supported. The transaction still completes and is pulsed.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The counter counts cycles in ISSUE/WAIT.
  - If it reaches TIMEOUT without sm_ack, drop sm_req, set mem_dat=0, set err=1 (sticky until reset) and go to RESP, so the core is released.
- Undefined: no counter, WAIT is unbounded, err is tied 0.

Decomposition:
- Package gpu_mem_pkg holds:
  - the arb_state enum (IDLE, ISSUE, WAIT, RESP);
  - ADDR_W and DATA_W defaults;
  - the core-id width constant (4).
- One sub-module, rr_picker: combinational round-robin selector (req vector, last_grant in; grant index and any_req out).

Test Plan:
- Single load: core 2 mem_req_ld=1, addr=0x3A5, memory returns 0x5C with sm_ack in ISSUE → sm_addr=0x3A5, sm_we=0, val_data=4'b0100 and mem_dat=0x5C exactly 3 cycles after the request.
- Store with wait: core 1 mem_req_st=1, addr=0x010, wdata=0xA7, sm_ack delayed 4 cycles → sm_we=1, sm_wdata=0xA7 held stable throughout, one val_data[1] pulse, mem_dat unchanged.
- Round robin: all 4 cores request loads continuously after reset → grant order 0,1,2,3,0; no core is granted twice in a row while others are waiting.
- Simultaneous ld+st on core 0 → treated as a load (sm_we=0).
- Reset while in WAIT: reset=0 for 1 cycle → sm_req, val_data and busy go 0 at once without a clock edge; after release the next grant goes to core 0.
- ARB_TIMEOUT_EN with TIMEOUT=8 and sm_ack never asserted → sm_req drops after 8 cycles, val_data pulses with mem_dat=0, err=1 and stays 1.
